// File: rtl/sd_host_cmd_engine_if.sv
// Host-side request/response bus of the SD command-line engine.
//   i_request/i_rtype/i_cmd/i_arg : command request from the host controller
//   o_busy/o_done/o_err           : transaction status
//   o_resp_idx/o_resp_arg         : decoded response fields
// master = host controller side, slave = command engine side.
interface sd_host_cmd_engine_if;
  logic         i_request;
  logic [1:0]   i_rtype;
  logic [5:0]   i_cmd;
  logic [31:0]  i_arg;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_err;
  logic [5:0]   o_resp_idx;
  logic [119:0] o_resp_arg;

  modport master (
    output i_request, i_rtype, i_cmd, i_arg,
    input  o_busy, o_done, o_err, o_resp_idx, o_resp_arg
  );

  modport slave (
    input  i_request, i_rtype, i_cmd, i_arg,
    output o_busy, o_done, o_err, o_resp_idx, o_resp_arg
  );
endinterface

// File: rtl/sd_host_cmd_engine.sv
// Host-side SD CMD-line engine. Sends one 48-bit command frame, waits for
// the response start bit, receives an R1/R6/R7, R2 or R3 response, checks
// framing and CRC7 and reports status.
// Ports:
//   i_clk, i_reset_n : system clock, synchronous active-low reset
//   i_ckstb          : one-cycle strobe per SD clock; CMD line activity only here
//   host             : request/response bus (slave side)
//   o_cmd_en         : host drives the CMD pin
//   o_cmd_data       : value driven on the CMD pin
//   i_cmd_line       : sampled CMD pin
module sd_host_cmd_engine #(
  parameter int unsigned TIMEOUT = 64,  // response start-bit wait, in strobes (<= 255)
  parameter int unsigned NCC     = 8    // idle strobes after each transaction (<= 255)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ckstb,
  sd_host_cmd_engine_if.slave  host,
  output logic                 o_cmd_en,
  output logic                 o_cmd_data,
  input  logic                 i_cmd_line
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_GAP} state_e;
  typedef enum logic [1:0] {ERR_OK, ERR_TIMEOUT, ERR_CRC, ERR_FRAME} err_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [47:0]   txsr_q, txsr_d;
  logic [133:0]  rxsr_q, rxsr_d;
  logic [6:0]    crc_q, crc_d;
  logic [1:0]    rtype_q, rtype_d;
  logic          cmd_en_q, cmd_en_d;
  logic          cmd_data_q, cmd_data_d;
  logic          done_q, done_d;
  err_e          err_q, err_d;
  logic [5:0]    idx_q, idx_d;
  logic [119:0]  arg_q, arg_d;

  // Received bits 1..N with the bit being sampled now in the LSB; bit k of
  // the frame sits at rx_w[len-1-k] once the last bit is present.
  logic [134:0]  rx_w;
  logic [7:0]    last_bit;
  logic          crc_cover;
  logic          trans_bad;
  logic          crc_bad;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0]  c;
    logic [39:0] s;
    c = '0;
    s = d;
    for (int unsigned i = 0; i < 40; i++) begin
      c = crc7_step(c, s[39]);
      s = {s[38:0], 1'b0};
    end
    return c;
  endfunction

  assign rx_w      = {rxsr_q, i_cmd_line};
  assign last_bit  = (rtype_q == 2'd2) ? 8'd135 : 8'd47;
  // The start bit is a leading zero and leaves a zero-initialised CRC
  // unchanged, so 48-bit coverage can begin at bit 1.
  assign crc_cover = ((rtype_q == 2'd1) && (cnt_q <= 8'd39)) ||
                     ((rtype_q == 2'd2) && (cnt_q >= 8'd8) && (cnt_q <= 8'd127));
  assign trans_bad = (rtype_q == 2'd2) ? rx_w[134] : rx_w[46];
  assign crc_bad   = (rtype_q != 2'd3) && (crc_q != rx_w[7:1]);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      txsr_q     <= '0;
      rxsr_q     <= '0;
      crc_q      <= '0;
      rtype_q    <= '0;
      cmd_en_q   <= 1'b0;
      cmd_data_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      idx_q      <= '0;
      arg_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txsr_q     <= txsr_d;
      rxsr_q     <= rxsr_d;
      crc_q      <= crc_d;
      rtype_q    <= rtype_d;
      cmd_en_q   <= cmd_en_d;
      cmd_data_q <= cmd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txsr_d     = txsr_q;
    rxsr_d     = rxsr_q;
    crc_d      = crc_q;
    rtype_d    = rtype_q;
    cmd_en_d   = cmd_en_q;
    cmd_data_d = cmd_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    case (state_q)
      S_IDLE: begin
        if (host.i_request) begin
          rtype_d = host.i_rtype;
          txsr_d  = {2'b01, host.i_cmd, host.i_arg,
                     crc7_40({2'b01, host.i_cmd, host.i_arg}), 1'b1};
          cnt_d   = '0;
          err_d   = ERR_OK;
          idx_d   = '0;
          arg_d   = '0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (i_ckstb) begin
          // Strobe 49 closes the end-bit period and releases the line.
          if (cnt_q == 8'd48) begin
            cmd_en_d   = 1'b0;
            cmd_data_d = 1'b1;
            cnt_d      = '0;
            crc_d      = '0;
            if (rtype_q == 2'd0) begin
              done_d  = 1'b1;
              err_d   = ERR_OK;
              state_d = S_GAP;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            cmd_en_d   = 1'b1;
            cmd_data_d = txsr_q[47];
            txsr_d     = {txsr_q[46:0], 1'b0};
            cnt_d      = cnt_q + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (i_ckstb) begin
          if (!i_cmd_line) begin
            cnt_d   = 8'd1;
            state_d = S_RX;
          end else if (32'(cnt_q) + 32'd1 == TIMEOUT) begin
            done_d  = 1'b1;
            err_d   = ERR_TIMEOUT;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_RX: begin
        if (i_ckstb) begin
          rxsr_d = rx_w[133:0];
          if (crc_cover) crc_d = crc7_step(crc_q, i_cmd_line);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == last_bit) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
            if (trans_bad || !i_cmd_line) err_d = ERR_FRAME;
            else if (crc_bad)             err_d = ERR_CRC;
            else                          err_d = ERR_OK;
            if (rtype_q == 2'd2) begin
              idx_d = rx_w[133:128];
              arg_d = rx_w[127:8];
            end else begin
              idx_d = rx_w[45:40];
              arg_d = {88'd0, rx_w[39:8]};
            end
          end
        end
      end
      S_GAP: begin
        if (i_ckstb) begin
          if (32'(cnt_q) + 32'd1 == NCC) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host.o_busy     = (state_q != S_IDLE);
    host.o_done     = done_q;
    host.o_err      = err_q;
    host.o_resp_idx = idx_q;
    host.o_resp_arg = arg_q;
    o_cmd_en        = cmd_en_q;
    o_cmd_data      = cmd_data_q;
  end

endmodule
